// File: rtl/reset_seq.sv
// Reset release sequencer: releases NUM_CHANNELS peripheral resets one at a time in index
// order with a programmable tick delay, plus per-channel software override and strap holds.
// Optional reverse-order power-down sequence is enabled by defining RESET_SEQ_PWRDN_EN.
// CSR map: BASE+0 CTRL, BASE+1 SWRST, BASE+2 DELAY.
module reset_seq #(
  parameter logic [4:0]  BASE_ADDR     = 5'h1d,
  parameter int unsigned NUM_CHANNELS  = 6,
  parameter int unsigned DELAY_WIDTH   = 4,
  parameter int unsigned DEFAULT_DELAY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic [4:0]              csr_a_i,
  input  logic [7:0]              csr_di_i,
  input  logic                    csr_we_i,
  output logic [7:0]              csr_do_o,
  input  logic                    start_i,
  input  logic [NUM_CHANNELS-1:0] hold_i,
  output logic [NUM_CHANNELS-1:0] rst_out_o,
  output logic                    done_o
);

  localparam int unsigned StepW = 3;
  localparam logic [StepW-1:0] LastStep = StepW'(NUM_CHANNELS - 1);
  localparam logic [DELAY_WIDTH-1:0] DelayRst = DELAY_WIDTH'(DEFAULT_DELAY);
  localparam logic [4:0] AddrSwrst = BASE_ADDR + 5'd1;
  localparam logic [4:0] AddrDelay = BASE_ADDR + 5'd2;

`ifdef RESET_SEQ_PWRDN_EN
  typedef enum logic [1:0] {StSeq, StDone, StDown, StOff} state_e;
`else
  typedef enum logic [0:0] {StSeq, StDone} state_e;
`endif

  state_e                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [StepW-1:0]        step_q, step_d;
  logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NUM_CHANNELS-1:0] swrst_q, swrst_d;
  logic [DELAY_WIDTH-1:0]  delay_q, delay_d;
  logic [NUM_CHANNELS-1:0] rst_out_q, rst_out_d;
  logic                    done_q, done_d;
  logic [NUM_CHANNELS-1:0] step_oh;
  logic                    fire, busy;
  logic                    ctrl_we, swrst_we, delay_we;
  logic [7:0]              rd_data;

  assign ctrl_we  = csr_we_i && (csr_a_i == BASE_ADDR);
  assign swrst_we = csr_we_i && (csr_a_i == AddrSwrst);
  assign delay_we = csr_we_i && (csr_a_i == AddrDelay);

`ifdef RESET_SEQ_PWRDN_EN
  assign busy = (state_q == StSeq) || (state_q == StDown);
`else
  assign busy = (state_q == StSeq);
`endif

  // Next-state: step timing, sequence/power-down progress, restart and CSR writes.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    swrst_d = swrst_q;
    delay_d = delay_q;
    step_oh = NUM_CHANNELS'(1) << step_q;
    // >= rather than == so a DELAY shrunk below cnt still releases on the next tick.
    fire    = (delay_q == '0) || (ce_i && (cnt_q >= delay_q - DELAY_WIDTH'(1)));
    cnt_inc = (ce_i && !fire) ? cnt_q + DELAY_WIDTH'(1) : cnt_q;

    unique case (state_q)
      StSeq: begin
        if (fire) begin
          mask_d = mask_q & ~step_oh;
          cnt_d  = '0;
          if (step_q == LastStep) begin
            state_d = StDone;
            step_d  = '0;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: mask_d = '0;
`ifdef RESET_SEQ_PWRDN_EN
      StDown: begin
        if (fire) begin
          mask_d = mask_q | step_oh;
          cnt_d  = '0;
          if (step_q == '0) begin
            state_d = StOff;
          end else begin
            step_d = step_q - StepW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StOff: mask_d = '1;
`endif
      default: state_d = StSeq;
    endcase

`ifdef RESET_SEQ_PWRDN_EN
    if (ctrl_we && csr_di_i[1] && ((state_q == StSeq) || (state_q == StDone))) begin
      state_d = StDown;
      mask_d  = mask_q;
      step_d  = LastStep;
      cnt_d   = '0;
    end
`endif

    // Restart overrides everything, including a simultaneous power-down request.
    if (start_i || (ctrl_we && csr_di_i[0])) begin
      state_d = StSeq;
      mask_d  = '1;
      step_d  = '0;
      cnt_d   = '0;
    end

    if (swrst_we) swrst_d = csr_di_i[NUM_CHANNELS-1:0];
    if (delay_we) delay_d = csr_di_i[DELAY_WIDTH-1:0];

    rst_out_d = mask_d | swrst_q | hold_i;
    done_d    = (state_d == StDone);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StSeq;
      mask_q    <= '1;
      step_q    <= '0;
      cnt_q     <= '0;
      swrst_q   <= '0;
      delay_q   <= DelayRst;
      rst_out_q <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      swrst_q   <= swrst_d;
      delay_q   <= delay_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
    end
  end

  // Combinational CSR read mux; zero when not addressed for the OR-combined bus.
  always_comb begin
    rd_data = '0;
    if (csr_a_i == BASE_ADDR) begin
      rd_data = {done_q, step_q, 1'b0, busy, 2'b00};
    end else if (csr_a_i == AddrSwrst) begin
      rd_data[NUM_CHANNELS-1:0] = swrst_q;
    end else if (csr_a_i == AddrDelay) begin
      rd_data[DELAY_WIDTH-1:0] = delay_q;
    end
  end

  assign csr_do_o  = rd_data;
  assign rst_out_o = rst_out_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: behavioural model checked every cycle plus directed literal checks.
module tb_reset_seq;

  localparam int N = 6;

  logic         clk, rst, ce, csr_we, start;
  logic [4:0]   csr_a;
  logic [7:0]   csr_di, csr_do;
  logic [N-1:0] hold, rst_out;
  logic         done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  reset_seq dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ce_i      (ce),
    .csr_a_i   (csr_a),
    .csr_di_i  (csr_di),
    .csr_we_i  (csr_we),
    .csr_do_o  (csr_do),
    .start_i   (start),
    .hold_i    (hold),
    .rst_out_o (rst_out),
    .done_o    (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=releasing, 1=all released, 2=powering down, 3=all held off.
  int           m_phase, m_idx, m_ticks;
  logic [N-1:0] m_mask, m_swrst, m_rst_out;
  logic [3:0]   m_delay;
  logic         m_done;
  int           o_phase;
  logic [N-1:0] o_mask, o_sw;
  bit           w_ctrl, w_sw, w_dl, ready;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_mask = '1; m_idx = 0; m_ticks = 0;
      m_swrst = '0; m_delay = 4'd2; m_rst_out = '1; m_done = 0;
    end else begin
      o_phase = m_phase; o_mask = m_mask; o_sw = m_swrst;
      w_ctrl = csr_we && csr_a == 5'h1d;
      w_sw   = csr_we && csr_a == 5'h1e;
      w_dl   = csr_we && csr_a == 5'h1f;
      // A step completes once the tick count since it began reaches DELAY.
      ready  = (m_delay == 0) || (ce && (m_ticks + 1 >= int'(m_delay)));
      if (m_phase == 0 || m_phase == 2) begin
        if (ready) begin
          m_ticks = 0;
          if (m_phase == 0) begin
            m_mask[m_idx] = 1'b0;
            if (m_idx == N - 1) begin m_phase = 1; m_idx = 0; end
            else m_idx++;
          end else begin
            m_mask[m_idx] = 1'b1;
            if (m_idx == 0) m_phase = 3;
            else m_idx--;
          end
        end else if (ce) begin
          m_ticks++;
        end
      end
`ifdef RESET_SEQ_PWRDN_EN
      if (w_ctrl && csr_di[1] && (o_phase == 0 || o_phase == 1)) begin
        m_phase = 2; m_idx = N - 1; m_ticks = 0; m_mask = o_mask;
      end
`endif
      if (start || (w_ctrl && csr_di[0])) begin
        m_phase = 0; m_mask = '1; m_idx = 0; m_ticks = 0;
      end
      if (w_sw) m_swrst = csr_di[N-1:0];
      if (w_dl) m_delay = csr_di[3:0];
      m_rst_out = m_mask | o_sw | hold;
      m_done = (m_phase == 1);
    end
  end

  function automatic logic [7:0] exp_rd(input logic [4:0] a);
    logic busy;
    busy = (m_phase == 0) || (m_phase == 2);
    case (a)
      5'h1d:   return {m_done, 3'(m_idx), 1'b0, busy, 2'b00};
      5'h1e:   return {2'b00, m_swrst};
      5'h1f:   return {4'h0, m_delay};
      default: return 8'h00;
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rst_out", 32'(rst_out), 32'(m_rst_out));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_csr_do", 32'(csr_do), 32'(exp_rd(csr_a)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1;
    tick();
    csr_we = 0; csr_a = 5'h00; csr_di = 8'h00;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(name, 32'(csr_do), 32'(exp));
    csr_a = 5'h00;
  endtask

  logic [N-1:0] tbl[6] = '{6'h3e, 6'h3c, 6'h38, 6'h30, 6'h20, 6'h00};
  logic [N-1:0] v;

  initial begin
    rst = 1; ce = 0; csr_we = 0; csr_a = 0; csr_di = 0; start = 0; hold = 0;
    repeat (3) tick();
    chk_en = 1;
    chk("reset_rst_out", 32'(rst_out), 32'h3f);
    chk("reset_done", 32'(done), 32'h0);
    rd("reset_ctrl", 5'h1d, 8'h04);
    rd("reset_delay", 5'h1f, 8'h02);
    rd("reset_swrst", 5'h1e, 8'h00);

    // DELAY=2, ce every 4 clk: one release per two ce pulses.
    rst = 0;
    for (int p = 1; p <= 12; p++) begin
      repeat (3) tick();
      ce = 1;
      tick();
      ce = 0;
      if (p % 2 == 0) chk("seq_d2_step", 32'(rst_out), 32'(tbl[p/2-1]));
      if (p == 11) chk("seq_d2_not_done", 32'(done), 32'h0);
      if (p == 12) chk("seq_d2_done", 32'(done), 32'h1);
    end

    // DELAY=0 restart: one release per clock.
    wr(5'h1f, 8'h00);
    wr(5'h1d, 8'h01);
    chk("d0_restart", 32'(rst_out), 32'h3f);
    for (int k = 1; k <= 6; k++) begin
      tick();
      v = 6'h3f;
      v = v << k;
      chk("d0_step", 32'(rst_out), 32'(v));
      if (k == 5) chk("d0_not_done", 32'(done), 32'h0);
    end
    chk("d0_done", 32'(done), 32'h1);
    rd("d0_ctrl", 5'h1d, 8'h80);

    // Software override and strap hold.
    hold = 6'h10;
    wr(5'h1e, 8'h05);
    tick();
    chk("swrst_hold", 32'(rst_out), 32'h15);
    rd("swrst_read", 5'h1e, 8'h05);
    hold = 6'h00;
    wr(5'h1e, 8'h00);
    tick();
    chk("swrst_clear", 32'(rst_out), 32'h00);

    // rst mid-sequence at step 3.
    wr(5'h1f, 8'h01);
    ce = 1;
    wr(5'h1d, 8'h01);
    chk("mid_restart", 32'(rst_out), 32'h3f);
    repeat (3) tick();
    chk("mid_step3", 32'(rst_out), 32'h38);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_all", 32'(rst_out), 32'h3f);
    chk("mid_rst_done", 32'(done), 32'h0);
    rd("mid_delay_back", 5'h1f, 8'h02);
    rd("mid_ctrl", 5'h1d, 8'h04);
    repeat (2) tick();
    chk("mid_resume_step0", 32'(rst_out), 32'h3e);
    ce = 0;

    // Unmapped addresses.
    wr(5'h1c, 8'hff);
    wr(5'h00, 8'hff);
    rd("bad_rd_1c", 5'h1c, 8'h00);
    rd("bad_rd_00", 5'h00, 8'h00);
    rd("bad_swrst", 5'h1e, 8'h00);
    rd("bad_delay", 5'h1f, 8'h02);

    // Power-down request from DONE.
    wr(5'h1f, 8'h01);
    ce = 1;
    wr(5'h1d, 8'h01);
    repeat (6) tick();
    chk("pd_pre_done", 32'(done), 32'h1);
    ce = 0;
    wr(5'h1d, 8'h02);
`ifdef RESET_SEQ_PWRDN_EN
    chk("pd_enter", 32'(rst_out), 32'h00);
    rd("pd_ctrl_busy", 5'h1d, 8'h54);
    ce = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      v = 6'h3f;
      v = v << (6 - k);
      chk("pd_step", 32'(rst_out), 32'(v));
    end
    ce = 0;
    chk("pd_off_done", 32'(done), 32'h0);
    rd("pd_off_ctrl", 5'h1d, 8'h00);
    wr(5'h1d, 8'h01);
    chk("pd_recover_restart", 32'(rst_out), 32'h3f);
    ce = 1;
    repeat (6) tick();
    ce = 0;
    chk("pd_recover_done", 32'(done), 32'h1);
`else
    tick();
    chk("pd_ignored_rst_out", 32'(rst_out), 32'h00);
    chk("pd_ignored_done", 32'(done), 32'h1);
    rd("pd_ignored_ctrl", 5'h1d, 8'h80);
`endif

    // Randomised traffic checked against the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      ce    = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 299) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) hold = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
      csr_we = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: csr_a = 5'h1d;
        1: csr_a = 5'h1e;
        2: csr_a = 5'h1f;
        default: csr_a = 5'($urandom);
      endcase
      if (csr_a == 5'h1d) csr_di = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      else if (csr_a == 5'h1f) csr_di = 8'($urandom_range(0, 3));
      else csr_di = 8'($urandom);
      tick();
    end
    rst = 0; start = 0; csr_we = 0; ce = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
